// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner decoder: segment codes, FSM states, defaults.
package seven_seg_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // Active-low segment codes {a,b,c,d,e,f,g}, a in the MSB
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational lookup from an active-low 7-segment pattern to a BCD value plus a valid flag.
module seg_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] value
);

    always_comb begin
        valid = 1'b1;
        value = 4'd0;
        case (seg)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment display bus after a stability filter.
// Optional saturating error counter enabled by defining SEVEN_SEG_DEC_ERR_CNT_EN.
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seven_seg,
    input  logic [3:0]  digit_sel,
`ifdef SEVEN_SEG_DEC_ERR_CNT_EN
    output logic [7:0]  err_cnt,
`endif
    output logic        digit_vld,
    output logic [1:0]  digit_idx,
    output logic [3:0]  digit_val,
    output logic        digit_odd,
    output logic [15:0] digits,
    output logic        err
);

    localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYCLES);
    localparam logic [10:0] CAND_RST   = {7'h7F, 4'h0};

    logic [7:0]  seg_p0_q, seg_p0_d, seg_p1_q, seg_p1_d;
    logic [3:0]  sel_p0_q, sel_p0_d, sel_p1_q, sel_p1_d;
    logic [10:0] prev_q, prev_d, cand;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic        eval, changed, blank, one_hot;
    logic [1:0]  sel_idx;
    logic        bcd_valid;
    logic [3:0]  bcd_value;
    logic        dp_unused;

    logic        vld_q, vld_d, err_q, err_d, odd_q, odd_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  val_q, val_d;
    logic [15:0] digits_q, digits_d;

    // Decimal point is carried through the synchronizer but never decoded
    assign dp_unused = seg_p1_q[0];

    assign cand    = {seg_p1_q[7:1], sel_p1_q};
    assign changed = (cand != prev_q);
    assign blank   = (sel_p1_q == 4'b0000);
    assign one_hot = $onehot(sel_p1_q);
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        case (sel_p1_q)
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    seg_to_bcd u_seg_to_bcd (
        .seg   (seg_p1_q[7:1]),
        .valid (bcd_valid),
        .value (bcd_value)
    );

    // Stage p0/p1: two-flop synchronizer, p1 output is the candidate
    always_comb begin
        seg_p0_d = seven_seg;
        seg_p1_d = seg_p0_q;
        sel_p0_d = digit_sel;
        sel_p1_d = sel_p0_q;
        prev_d   = cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p0_q <= 8'hFF;
            seg_p1_q <= 8'hFF;
            sel_p0_q <= 4'h0;
            sel_p1_q <= 4'h0;
            prev_q   <= CAND_RST;
        end else begin
            seg_p0_q <= seg_p0_d;
            seg_p1_q <= seg_p1_d;
            sel_p0_q <= sel_p0_d;
            sel_p1_q <= sel_p1_d;
            prev_q   <= prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A change always restarts the count, even on the cycle the count would complete
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eval    = 1'b0;
        if (blank) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else if (changed) begin
            state_d = ST_COUNT;
            cnt_d   = 8'd0;
        end else if (state_q == ST_COUNT) begin
            if (cnt_inc == STABLE_LIM) begin
                eval    = 1'b1;
                state_d = ST_HELD;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_comb begin
        vld_d    = 1'b0;
        err_d    = 1'b0;
        idx_d    = idx_q;
        val_d    = val_q;
        odd_d    = odd_q;
        digits_d = digits_q;
        if (eval) begin
            if (one_hot && bcd_valid) begin
                vld_d = 1'b1;
                idx_d = sel_idx;
                val_d = bcd_value;
                odd_d = bcd_value[0];
                digits_d[{sel_idx, 2'b00} +: 4] = bcd_value;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Stage p2: registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= 2'd0;
            val_q    <= 4'd0;
            odd_q    <= 1'b0;
            digits_q <= 16'h0000;
        end else begin
            vld_q    <= vld_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            odd_q    <= odd_d;
            digits_q <= digits_d;
        end
    end

    assign digit_vld = vld_q;
    assign err       = err_q;
    assign digit_idx = idx_q;
    assign digit_val = val_q;
    assign digit_odd = odd_q;
    assign digits    = digits_q;

`ifdef SEVEN_SEG_DEC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
